sparse_mult_arbiter: RTL
========================

# sparse_mult_arbiter

Round-robin scheduler that shares one sparse-multiply engine (block-in, single-word-out, e.g. multiply-by-E) among NUM_REQ requester streams. Grants the engine one full input block (BLOCK_LEN beats) at a time and never splits a block. Records the owner of each granted block in an in-order tag FIFO, and returns each engine result tagged with the owning requester ID. Sits between the per-codeword encoder lanes and the shared engine instance.

## Interface
Parameters:
- WIDTH, 96, data word width (requester, engine and result)
- NUM_REQ, 4, number of requesters, 2..16
- BLOCK_LEN, 11, input beats per engine block
- TAG_DEPTH, 4, maximum outstanding blocks (granted, result not yet returned); power of two

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_req_data  in  NUM_REQ*WIDTH  requester words; requester k at [k*WIDTH +: WIDTH]
- i_req_valid  in  NUM_REQ  per-requester valid
- o_req_ready  out  NUM_REQ  per-requester ready
- o_eng_data  out  WIDTH  word to engine
- o_eng_valid  out  1  engine input valid
- i_eng_ready  in  1  engine input ready
- i_eng_data  in  WIDTH  engine result
- i_eng_valid  in  1  engine result valid
- o_eng_ready  out  1  result accepted from engine
- o_res_data  out  WIDTH  result to requesters
- o_res_id  out  IDW  owner of o_res_data; IDW = max(1, clog2(NUM_REQ))
- o_res_valid  out  1  result valid
- i_res_ready  in  1  result sink ready
- o_err  out  1  sticky: engine produced a result with no outstanding tag

## Operation
- Input FSM states: ST_IDLE, ST_STREAM.
- ST_IDLE: all o_req_ready = 0, o_eng_valid = 0, o_eng_data = 0. If any i_req_valid is set and tag count < TAG_DEPTH, select the first valid requester searching upward from last_grant+1 (mod NUM_REQ). Register grant and last_grant, push grant ID into the tag FIFO, clear beat_cnt, go to ST_STREAM. Otherwise stay in ST_IDLE.
- ST_STREAM: pass-through for the granted requester only.
  - o_eng_data = i_req_data[grant]
  - o_eng_valid = i_req_valid[grant]
  - o_req_ready[grant] = i_eng_ready; all other ready bits are 0
  - beat_cnt increments on each handshake.
  - The handshake at beat_cnt == BLOCK_LEN-1 returns the FSM to ST_IDLE.
- Full-FIFO check uses the registered count. A pop in the same cycle does not enable a grant.
- Result path (independent of the FSM):
  - o_res_data = i_eng_data
  - o_res_id = tag FIFO head
  - o_res_valid = i_eng_valid & !tag_empty
  - o_eng_ready = i_res_ready & !tag_empty
  - Pop the tag FIFO on i_eng_valid & o_eng_ready.
- Simultaneous push (grant) and pop in one cycle: count is unchanged, both take effect.
- i_eng_valid with tag FIFO empty: o_err is set and held until reset; o_eng_ready stays 0.
- A requester dropping valid mid-block stalls the block; the grant is held (no timeout, no preemption).

## Timing
- Reset values: o_req_ready 0, o_eng_valid 0, o_eng_data 0, o_eng_ready 0, o_res_valid 0, o_res_id 0, o_err 0.
- After reset: FSM = ST_IDLE, tag FIFO empty, last_grant = NUM_REQ-1, so requester 0 has priority first.
- Arbitration latency: valid seen in ST_IDLE at cycle N → first beat can transfer at cycle N+1.
- Minimum block period: BLOCK_LEN+1 cycles (one arbitration cycle per block).
- Forward data path and result path are combinational, with zero added latency.
- Reset mid-block: the partial block is abandoned and all tags are dropped. The engine must be reset on the same i_reset.

## Structure
- Package sparse_mult_arbiter_pkg:
  - states_t enum (ST_IDLE, ST_STREAM)
  - default parameter constants
  - function next_rr(valid, last) returning the round-robin winner
- Sub-module sparse_mult_tag_fifo: synchronous FIFO, parameters DEPTH and IDW. Provides push, pop, head, empty, and count. Push and pop in the same cycle are legal.
- Top level contains the FSM, beat counter, grant/last_grant registers, muxes, and error flag.

## Test plan
- Single requester: requester 1 sends words 1..11 with no backpressure; engine model returns the last word. Required: engine sees 11 contiguous beats from cycle 1 after valid; o_res_valid with o_res_data = 11, o_res_id = 1.
- All 4 requesters valid continuously. Required: grant order 0,1,2,3,0; each block is 11 contiguous beats from one requester; exactly 1 idle cycle between blocks; result IDs 0,1,2,3,0.
- Backpressure: i_eng_ready toggles every cycle during a block. Required: beat_cnt advances only on handshakes; o_req_ready[grant] mirrors i_eng_ready; block completes after 11 handshakes.
- Tag FIFO full: i_res_ready = 0 and the engine holds results. Required: after 4 grants no fifth grant occurs. Raising i_res_ready pops one tag, and the next grant follows one cycle later.
- Spurious result: i_eng_valid = 1 with no outstanding block. Required: o_err = 1 and stays 1; o_res_valid = 0; o_eng_ready = 0.
- Reset at beat 5 of a block from requester 2. Required: all outputs return to their reset values; with all requesters valid after reset, the next grant goes to requester 0.

Source files
------------

// File: rtl/sparse_mult_arbiter_pkg.sv
// sparse_mult_arbiter_pkg: shared types, default sizes and round-robin helper for the sparse-multiply arbiter
package sparse_mult_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_STREAM} states_t;
  localparam int DEF_WIDTH     = 96;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BLOCK_LEN = 11;
  localparam int DEF_TAG_DEPTH = 4;
  localparam int MAX_REQ       = 16;
  // scanning from farthest to nearest lets the nearest valid requester after last win
  function automatic logic [3:0] next_rr(input logic [MAX_REQ-1:0] valid, input logic [3:0] last, input int n);
    int idx;
    logic [3:0] w;
    w = last;
    for (int i = n; i >= 1; i--) begin
      idx = (int'(last) + i) % n;
      if (valid[idx]) w = 4'(idx);
    end
    return w;
  endfunction
endpackage

// File: rtl/sparse_mult_tag_fifo.sv
// sparse_mult_tag_fifo: in-order FIFO of owner IDs for blocks granted to the engine but not yet answered
module sparse_mult_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int IDW = 2,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           push,
  input  logic [IDW-1:0] din,
  input  logic           pop,
  output logic [IDW-1:0] head,
  output logic           empty,
  output logic [CW-1:0]  count
);
  logic [IDW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    empty = count == '0;
    do_pop = pop && !empty;
    do_push = push && (count != CW'(DEPTH) || do_pop);
    head = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH-1) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sparse_mult_arbiter.sv
// sparse_mult_arbiter: round-robin block scheduler sharing one sparse-multiply engine, tagging results with owner ID
module sparse_mult_arbiter
  import sparse_mult_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH,
  localparam int IDW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [WIDTH-1:0]     o_eng_data,
  output logic                 o_eng_valid,
  input  logic                 i_eng_ready,
  input  logic [WIDTH-1:0]     i_eng_data,
  input  logic                 i_eng_valid,
  output logic                 o_eng_ready,
  output logic [WIDTH-1:0]     o_res_data,
  output logic [IDW-1:0]       o_res_id,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic                 o_err
);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam int BW = BLOCK_LEN > 1 ? $clog2(BLOCK_LEN) : 1;
  states_t state;
  logic [IDW-1:0] grant, last_grant, winner, head;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] count;
  logic empty, can_grant, streaming, hs, pop;
  sparse_mult_tag_fifo #(.DEPTH(TAG_DEPTH), .IDW(IDW)) u_tags (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .push(can_grant),
    .din(winner),
    .pop(pop),
    .head(head),
    .empty(empty),
    .count(count)
  );
  // full check uses the registered count, so a same-cycle pop never frees a slot for this grant
  always_comb begin
    winner = IDW'(next_rr(MAX_REQ'(i_req_valid), 4'(last_grant), NUM_REQ));
    can_grant = state == ST_IDLE && |i_req_valid && count < CW'(TAG_DEPTH);
    streaming = state == ST_STREAM;
    hs = streaming && i_req_valid[grant] && i_eng_ready;
    o_eng_valid = streaming && i_req_valid[grant];
    o_eng_data = streaming ? i_req_data[int'(grant)*WIDTH +: WIDTH] : '0;
    o_req_ready = streaming && i_eng_ready ? NUM_REQ'(1) << grant : '0;
    o_eng_ready = i_res_ready && !empty;
    o_res_valid = i_eng_valid && !empty;
    o_res_data = i_eng_data;
    o_res_id = head;
    pop = i_eng_valid && o_eng_ready;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
      grant <= '0;
      last_grant <= IDW'(NUM_REQ-1);
      beat_cnt <= '0;
      o_err <= 1'b0;
    end else begin
      if (i_eng_valid && empty) o_err <= 1'b1;
      case (state)
        ST_IDLE: if (can_grant) begin
          grant <= winner;
          last_grant <= winner;
          beat_cnt <= '0;
          state <= ST_STREAM;
        end
        ST_STREAM: if (hs) begin
          beat_cnt <= beat_cnt + BW'(1);
          if (beat_cnt == BW'(BLOCK_LEN-1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
